// File: rtl/kick_arbiter.sv
// Purpose: sequences team/opponent kicks into the ball datapath, with charge, cooldown and serve timing.
// Latency: all outputs registered; a kick request is seen as kickValid on the next cycle.
// Backpressure: none; requests arriving outside PLAY are dropped and never queued.
//
// Ports:
//   clk, reset (async active-high)      clock and reset
//   startOfFrame                        one-cycle frame tick
//   teamCollision/oppCollision          ball touching a player of that side (level)
//   teamChargeKey/oppChargeKey          kick key held (level)
//   teamRelease/oppRelease              kick key released (pulse)
//   goalWasScored[1:0]                  01 team goal, 10 opponent goal
//   kickValid/kickOwner/kickStrength    one-cycle kick command (owner 0 team, 1 opponent)
//   holdBall                            a charging player holds the ball
//   serveReq                            one-cycle re-launch pulse after a goal
//   cooldownActive, state[1:0]          FSM status
module kick_arbiter #(
  parameter int MAX_CHARGE      = 160,
  parameter int COOLDOWN_FRAMES = 20,
  parameter int SERVE_DELAY     = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       teamCollision,
  input  logic       oppCollision,
  input  logic       teamChargeKey,
  input  logic       teamRelease,
  input  logic       oppChargeKey,
  input  logic       oppRelease,
  input  logic [1:0] goalWasScored,
  output logic       kickValid,
  output logic       kickOwner,
  output logic [8:0] kickStrength,
  output logic       holdBall,
  output logic       serveReq,
  output logic       cooldownActive,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_PLAY      = 2'b00,
    S_KICK      = 2'b01,
    S_COOLDOWN  = 2'b10,
    S_GOAL_WAIT = 2'b11
  } state_t;

  localparam logic [8:0] CHG_MAX    = 9'(MAX_CHARGE);
  localparam logic [7:0] CD_LAST    = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_DELAY - 1);

  state_t     st;
  state_t     st_nxt;
  logic [8:0] team_chg;
  logic [8:0] opp_chg;
  logic [7:0] frame_cnt;
  logic       last_owner;

  logic goal;
  logic team_req;
  logic opp_req;
  logic any_req;
  logic team_wins;
  logic cd_done;
  logic serve_done;

  assign state = st;

  always_comb begin
    // 00 and 11 are both "no goal"
    goal       = (goalWasScored == 2'b01) || (goalWasScored == 2'b10);
    team_req   = teamCollision & teamRelease;
    opp_req    = oppCollision & oppRelease;
    any_req    = team_req | opp_req;
    // On a tie the side that did not kick last wins.
    team_wins  = team_req & (~opp_req | last_owner);
    cd_done    = startOfFrame && (frame_cnt == CD_LAST);
    serve_done = startOfFrame && (frame_cnt == SERVE_LAST);

    st_nxt = st;
    case (st)
      S_PLAY: begin
        if (goal)         st_nxt = S_GOAL_WAIT;
        else if (any_req) st_nxt = S_KICK;
      end
      S_KICK:      st_nxt = goal ? S_GOAL_WAIT : S_COOLDOWN;
      S_COOLDOWN: begin
        if (goal)         st_nxt = S_GOAL_WAIT;
        else if (cd_done) st_nxt = S_PLAY;
      end
      S_GOAL_WAIT: begin
        if (serve_done)   st_nxt = S_PLAY;
      end
      default:     st_nxt = S_PLAY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st             <= S_PLAY;
      team_chg       <= '0;
      opp_chg        <= '0;
      frame_cnt      <= '0;
      last_owner     <= 1'b1;
      kickValid      <= 1'b0;
      kickOwner      <= 1'b0;
      kickStrength   <= '0;
      holdBall       <= 1'b0;
      serveReq       <= 1'b0;
      cooldownActive <= 1'b0;
    end else begin
      st             <= st_nxt;
      kickValid      <= 1'b0;
      kickOwner      <= 1'b0;
      kickStrength   <= '0;
      serveReq       <= 1'b0;
      cooldownActive <= (st_nxt == S_COOLDOWN);
      holdBall       <= (st_nxt == S_PLAY) &&
                        ((teamCollision && teamChargeKey) || (oppCollision && oppChargeKey));

      // Frame counter restarts on every state change and only counts while waiting.
      if (st_nxt != st)
        frame_cnt <= '0;
      else if (startOfFrame && ((st == S_COOLDOWN) || (st == S_GOAL_WAIT)))
        frame_cnt <= frame_cnt + 8'd1;

      // Charge accumulation; later assignments below take priority.
      if ((st == S_PLAY) && startOfFrame && teamChargeKey && (team_chg < CHG_MAX))
        team_chg <= team_chg + 9'd1;
      if ((st == S_PLAY) && startOfFrame && oppChargeKey && (opp_chg < CHG_MAX))
        opp_chg <= opp_chg + 9'd1;
      if (teamRelease && !teamCollision) team_chg <= '0;
      if (oppRelease && !oppCollision)   opp_chg  <= '0;

      case (st)
        S_PLAY: begin
          if (!goal && any_req) begin
            kickValid    <= 1'b1;
            kickOwner    <= ~team_wins;
            // Strength is the charge before any increment at this edge.
            kickStrength <= team_wins ? team_chg : opp_chg;
            // Winner's charge is spent, loser's is discarded.
            if (team_req) team_chg <= '0;
            if (opp_req)  opp_chg  <= '0;
          end
        end
        S_KICK:      last_owner <= kickOwner;
        S_GOAL_WAIT: if (serve_done) serveReq <= 1'b1;
        default: ;
      endcase

      // Charges are zeroed on entering and throughout the goal wait.
      if (st_nxt == S_GOAL_WAIT) begin
        team_chg <= '0;
        opp_chg  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_kick_arbiter.sv
module tb_kick_arbiter;

  localparam int MAXC  = 160;
  localparam int CDF   = 20;
  localparam int SERVE = 30;

  localparam int PLAY = 0, KICK = 1, CD = 2, GW = 3;

  logic       clk;
  logic       reset;
  logic       startOfFrame;
  logic       teamCollision;
  logic       oppCollision;
  logic       teamChargeKey;
  logic       teamRelease;
  logic       oppChargeKey;
  logic       oppRelease;
  logic [1:0] goalWasScored;
  logic       kickValid;
  logic       kickOwner;
  logic [8:0] kickStrength;
  logic       holdBall;
  logic       serveReq;
  logic       cooldownActive;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 0;

  kick_arbiter #(
    .MAX_CHARGE(MAXC), .COOLDOWN_FRAMES(CDF), .SERVE_DELAY(SERVE)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .teamCollision(teamCollision), .oppCollision(oppCollision),
    .teamChargeKey(teamChargeKey), .teamRelease(teamRelease),
    .oppChargeKey(oppChargeKey), .oppRelease(oppRelease),
    .goalWasScored(goalWasScored),
    .kickValid(kickValid), .kickOwner(kickOwner), .kickStrength(kickStrength),
    .holdBall(holdBall), .serveReq(serveReq), .cooldownActive(cooldownActive),
    .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus frames-remaining countdown.
  int m_st, m_tc, m_oc, m_left, m_last;
  int m_kv, m_ko, m_ks, m_hold, m_serve;
  int old_tc, old_oc, prev_owner;
  bit goal, treq, oreq, team_first;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_st = PLAY; m_tc = 0; m_oc = 0; m_left = 0; m_last = 1;
        m_kv = 0; m_ko = 0; m_ks = 0; m_hold = 0; m_serve = 0;
      end else begin
        goal = (goalWasScored == 2'b01) || (goalWasScored == 2'b10);
        treq = teamCollision && teamRelease;
        oreq = oppCollision && oppRelease;
        prev_owner = m_ko;
        old_tc = m_tc;
        old_oc = m_oc;
        m_kv = 0; m_ko = 0; m_ks = 0; m_serve = 0;
        if (m_st == PLAY && startOfFrame) begin
          if (teamChargeKey) m_tc = (m_tc + 1 > MAXC) ? MAXC : m_tc + 1;
          if (oppChargeKey)  m_oc = (m_oc + 1 > MAXC) ? MAXC : m_oc + 1;
        end
        if (teamRelease && !teamCollision) m_tc = 0;
        if (oppRelease && !oppCollision)   m_oc = 0;
        case (m_st)
          PLAY: begin
            if (goal) begin
              m_st = GW; m_left = SERVE; m_tc = 0; m_oc = 0;
            end else if (treq || oreq) begin
              team_first = treq && (!oreq || m_last == 1);
              m_kv = 1;
              m_ko = team_first ? 0 : 1;
              m_ks = team_first ? old_tc : old_oc;
              if (treq) m_tc = 0;
              if (oreq) m_oc = 0;
              m_st = KICK;
            end
          end
          KICK: begin
            m_last = prev_owner;
            if (goal) begin
              m_st = GW; m_left = SERVE; m_tc = 0; m_oc = 0;
            end else begin
              m_st = CD; m_left = CDF;
            end
          end
          CD: begin
            if (goal) begin
              m_st = GW; m_left = SERVE; m_tc = 0; m_oc = 0;
            end else if (startOfFrame) begin
              m_left--;
              if (m_left == 0) m_st = PLAY;
            end
          end
          default: begin
            m_tc = 0; m_oc = 0;
            if (startOfFrame) begin
              m_left--;
              if (m_left == 0) begin
                m_st = PLAY; m_serve = 1;
              end
            end
          end
        endcase
        m_hold = (m_st == PLAY &&
                  ((teamCollision && teamChargeKey) || (oppCollision && oppChargeKey))) ? 1 : 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (run_cmp) begin
        chk("state", int'(state), m_st);
        chk("kickValid", int'(kickValid), m_kv);
        chk("kickOwner", int'(kickOwner), m_ko);
        chk("kickStrength", int'(kickStrength), m_ks);
        chk("holdBall", int'(holdBall), m_hold);
        chk("serveReq", int'(serveReq), m_serve);
        chk("cooldownActive", int'(cooldownActive), (m_st == CD) ? 1 : 0);
        chk("team_charge", int'(dut.team_chg), m_tc);
        chk("opp_charge", int'(dut.opp_chg), m_oc);
        chk("kick_serve_excl", int'(kickValid & serveReq), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    tick();
  endtask

  task automatic clear_inputs();
    startOfFrame = 0; teamCollision = 0; oppCollision = 0;
    teamChargeKey = 0; teamRelease = 0; oppChargeKey = 0; oppRelease = 0;
    goalWasScored = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    #2;
    reset = 1'b1;
    run_cmp = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_state", int'(state), 0);
    chk("rst_kickValid", int'(kickValid), 0);
    chk("rst_lastOwner", int'(dut.last_owner), 1);

    // 1) ten frames of charge while touching the ball, then kick
    teamCollision = 1; teamChargeKey = 1;
    frame();
    chk("t1_hold", int'(holdBall), 1);
    repeat (9) frame();
    chk("t1_charge", int'(dut.team_chg), 10);
    teamChargeKey = 0; teamRelease = 1;
    tick();
    chk("t1_kv", int'(kickValid), 1);
    chk("t1_owner", int'(kickOwner), 0);
    chk("t1_strength", int'(kickStrength), 10);
    chk("t1_kick_state", int'(state), 1);
    teamRelease = 0; teamCollision = 0;
    tick();
    chk("t1_cd_state", int'(state), 2);
    chk("t1_cd_active", int'(cooldownActive), 1);
    repeat (CDF - 1) frame();
    chk("t1_cd_frame19", int'(state), 2);
    frame();
    chk("t1_play_again", int'(state), 0);

    // 2) saturation
    teamChargeKey = 1;
    repeat (200) frame();
    chk("t2_sat", int'(dut.team_chg), 160);
    teamChargeKey = 0; teamCollision = 1; teamRelease = 1;
    tick();
    chk("t2_strength", int'(kickStrength), 160);
    teamCollision = 0; teamRelease = 0;
    tick();
    repeat (CDF) frame();
    chk("t2_play", int'(state), 0);

    // 3) simultaneous requests alternate starting with the team
    do_reset();
    teamChargeKey = 1; oppChargeKey = 1;
    repeat (5) frame();
    teamChargeKey = 0; oppChargeKey = 0;
    teamCollision = 1; oppCollision = 1; teamRelease = 1; oppRelease = 1;
    tick();
    chk("t3a_owner", int'(kickOwner), 0);
    chk("t3a_strength", int'(kickStrength), 5);
    chk("t3a_opp_cleared", int'(dut.opp_chg), 0);
    clear_inputs();
    tick();
    repeat (CDF) frame();
    teamChargeKey = 1; oppChargeKey = 1;
    repeat (4) frame();
    oppChargeKey = 0;
    repeat (3) frame();
    teamChargeKey = 0;
    teamCollision = 1; oppCollision = 1; teamRelease = 1; oppRelease = 1;
    tick();
    chk("t3b_owner", int'(kickOwner), 1);
    chk("t3b_strength", int'(kickStrength), 4);
    chk("t3b_team_cleared", int'(dut.team_chg), 0);
    clear_inputs();
    tick();

    // 4) request in cooldown is ignored
    repeat (5) frame();
    teamCollision = 1; teamRelease = 1;
    tick();
    chk("t4_no_kick", int'(kickValid), 0);
    chk("t4_still_cd", int'(state), 2);
    clear_inputs();
    repeat (CDF - 6) frame();
    chk("t4_cd_19", int'(state), 2);
    frame();
    chk("t4_play", int'(state), 0);

    // 5) goal codes, goal beats kick, serve timing
    goalWasScored = 2'b11;
    tick();
    chk("t5_11_ignored", int'(state), 0);
    goalWasScored = 2'b00;
    teamChargeKey = 1;
    repeat (3) frame();
    teamChargeKey = 0;
    goalWasScored = 2'b01; teamCollision = 1; teamRelease = 1;
    tick();
    chk("t5_goal_state", int'(state), 3);
    chk("t5_no_kick", int'(kickValid), 0);
    chk("t5_charge0", int'(dut.team_chg), 0);
    clear_inputs();
    oppChargeKey = 1;
    repeat (SERVE - 1) frame();
    chk("t5_wait29", int'(state), 3);
    startOfFrame = 1;
    tick();
    chk("t5_serve", int'(serveReq), 1);
    chk("t5_play", int'(state), 0);
    startOfFrame = 0;
    tick();
    chk("t5_serve_pulse", int'(serveReq), 0);
    oppChargeKey = 0;

    // 6) reset in cooldown, goal during kick, reset in goal wait
    oppChargeKey = 1;
    repeat (2) frame();
    oppChargeKey = 0; oppCollision = 1; oppRelease = 1;
    tick();
    chk("t6_opp_kick", int'(kickStrength), 2);
    clear_inputs();
    tick();
    repeat (3) frame();
    reset = 1;
    #1;
    chk("t6a_state", int'(state), 0);
    chk("t6a_cd", int'(cooldownActive), 0);
    tick();
    reset = 0;
    tick();
    teamChargeKey = 1;
    repeat (4) frame();
    teamChargeKey = 0; teamCollision = 1; teamRelease = 1;
    tick();
    goalWasScored = 2'b10; teamCollision = 0; teamRelease = 0;
    chk("t6_kick_issued", int'(kickValid), 1);
    tick();
    chk("t6_goal_after_kick", int'(state), 3);
    goalWasScored = 2'b00;
    teamChargeKey = 1; teamCollision = 1;
    repeat (4) frame();
    chk("t6_gw_hold0", int'(holdBall), 0);
    reset = 1;
    #1;
    chk("t6b_state", int'(state), 0);
    chk("t6b_charge", int'(dut.team_chg), 0);
    tick();
    clear_inputs();
    reset = 0;
    tick();
    chk("t6b_play", int'(state), 0);

    run_cmp = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
